// File: rtl/shift_add_multiplier_4.sv
// Sequential unsigned shift-and-add multiplier. The datapath adder is a chain of 4-bit slices.
// Build macro MUL_ZERO_SKIP_EN: a zero operand skips RUN and goes straight to DONE with p=0.
module shift_add_multiplier_4 #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] p,
  output logic               busy,
  output logic               done
);
  // state | meaning
  // IDLE  | waiting for start
  // RUN   | one add/shift step per clock, WIDTH steps
  // DONE  | p valid, done pulse; a new start is accepted here
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int CW  = $clog2(WIDTH) + 1;
  localparam int NSL = WIDTH / 4;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] m_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] q_reg;
  logic             c_reg;
  logic [CW-1:0]    count;

  logic [WIDTH-1:0] sum;
  logic             carry;
  logic [4:0]       slice;
  logic [WIDTH:0]   step_ca;
  logic [WIDTH-1:0] a_next;
  logic [WIDTH-1:0] q_next;
  logic             skip;

  // C is always zero at the start of a step (the shift empties it), so it doubles as carry-in.
  always_comb begin
    sum   = '0;
    slice = '0;
    carry = c_reg;
    for (int i = 0; i < NSL; i++) begin
      slice = {1'b0, a_reg[4*i +: 4]} + {1'b0, m_reg[4*i +: 4]} + {4'b0, carry};
      sum[4*i +: 4] = slice[3:0];
      carry = slice[4];
    end
  end

  assign step_ca = q_reg[0] ? {carry, sum} : {1'b0, a_reg};
  assign a_next  = step_ca[WIDTH:1];
  assign q_next  = {step_ca[0], q_reg[WIDTH-1:1]};

`ifdef MUL_ZERO_SKIP_EN
  assign skip = (a == '0) || (b == '0);
`else
  assign skip = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      m_reg <= '0;
      a_reg <= '0;
      q_reg <= '0;
      c_reg <= 1'b0;
      count <= '0;
      p     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            m_reg <= a;
            q_reg <= b;
            a_reg <= '0;
            c_reg <= 1'b0;
            count <= '0;
            if (skip) begin
              p     <= '0;
              state <= DONE;
            end else begin
              state <= RUN;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_reg <= a_next;
          q_reg <= q_next;
          c_reg <= 1'b0;
          count <= count + CW'(1);
          if (count == LAST) begin
            p     <= {a_next, q_next};
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
endmodule

// File: tb/tb_shift_add_multiplier_4.sv
// Directed bench for shift_add_multiplier_4 (WIDTH=4); honours MUL_ZERO_SKIP_EN for zero-operand latency.
module tb_shift_add_multiplier_4;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic [7:0] p;
  logic       busy;
  logic       done;

  int checks = 0;
  int failures = 0;

`ifdef MUL_ZERO_SKIP_EN
  localparam int ZLAT = 1;
  localparam int ZBUSY = 0;
`else
  localparam int ZLAT = 5;
  localparam int ZBUSY = 4;
`endif

  shift_add_multiplier_4 #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .p(p), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if (p !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_in got p=%h busy=%b done=%b exp p=00 busy=0 done=0", p, busy, done);
    end
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (p !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d got p=%h busy=%b done=%b exp p=00 busy=0 done=0", k, p, busy, done);
      end
    end
  endtask

  task automatic test_basic();
    int lat;
    int busy_cnt;
    bit p_moved;
    a = 4'd15; b = 4'd15; start = 1'b1;
    step();
    start = 1'b0;
    lat = 1; busy_cnt = 0; p_moved = 0;
    while (!done && lat < 20) begin
      if (busy) busy_cnt++;
      if (p !== 8'h00) p_moved = 1;
      step();
      lat++;
    end
    checks++;
    if (done !== 1'b1 || lat !== 5) begin
      failures++;
      $display("FAIL basic_latency got lat=%0d done=%b exp lat=5 done=1", lat, done);
    end
    checks++;
    if (busy_cnt !== 4) begin
      failures++;
      $display("FAIL basic_busy got busy_cycles=%0d exp 4", busy_cnt);
    end
    checks++;
    if (p_moved) begin
      failures++;
      $display("FAIL basic_p_stable got p changed during RUN exp held 00");
    end
    checks++;
    if (p !== 8'hE1) begin
      failures++;
      $display("FAIL basic_p got=%h exp=e1", p);
    end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || p !== 8'hE1) begin
      failures++;
      $display("FAIL basic_after got done=%b busy=%b p=%h exp done=0 busy=0 p=e1", done, busy, p);
    end
  endtask

  task automatic test_ignore_start();
    int pulses;
    logic [7:0] pd;
    a = 4'd9; b = 4'd6; start = 1'b1;
    step();
    start = 1'b0;
    pulses = 0; pd = '0;
    for (int k = 0; k < 12; k++) begin
      if (k == 1) begin
        start = 1'b1; a = 4'd1; b = 4'd1;
      end
      step();
      start = 1'b0;
      if (done) begin
        pulses++;
        pd = p;
      end
    end
    checks++;
    if (pulses !== 1) begin
      failures++;
      $display("FAIL ignore_pulses got=%0d exp=1", pulses);
    end
    checks++;
    if (pd !== 8'h36) begin
      failures++;
      $display("FAIL ignore_p got=%h exp=36", pd);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    a = 4'd7; b = 4'd5; start = 1'b1;
    step();
    start = 1'b0;
    lat = 1;
    while (!done && lat < 20) begin
      step();
      lat++;
    end
    checks++;
    if (done !== 1'b1 || lat !== 5 || p !== 8'd35) begin
      failures++;
      $display("FAIL b2b_first got done=%b lat=%0d p=%0d exp done=1 lat=5 p=35", done, lat, p);
    end
    a = 4'd3; b = 4'd4; start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || p !== 8'd35) begin
      failures++;
      $display("FAIL b2b_no_bubble got busy=%b done=%b p=%0d exp busy=1 done=0 p=35", busy, done, p);
    end
    lat = 1;
    while (!done && lat < 20) begin
      step();
      lat++;
    end
    checks++;
    if (done !== 1'b1 || lat !== 5 || p !== 8'd12) begin
      failures++;
      $display("FAIL b2b_second got done=%b lat=%0d p=%0d exp done=1 lat=5 p=12", done, lat, p);
    end
    step();
  endtask

  task automatic test_reset_abort();
    int pulses;
    int lat;
    a = 4'd13; b = 4'd11; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    checks++;
    if (p !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL abort_reset got p=%h busy=%b done=%b exp p=00 busy=0 done=0", p, busy, done);
    end
    reset = 1'b0;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (done || busy) pulses++;
    end
    checks++;
    if (pulses !== 0 || p !== 8'h00) begin
      failures++;
      $display("FAIL abort_quiet got active_cycles=%0d p=%h exp 0 and 00", pulses, p);
    end
    a = 4'd13; b = 4'd11; start = 1'b1;
    step();
    start = 1'b0;
    lat = 1;
    while (!done && lat < 20) begin
      step();
      lat++;
    end
    checks++;
    if (done !== 1'b1 || lat !== 5 || p !== 8'd143) begin
      failures++;
      $display("FAIL abort_restart got done=%b lat=%0d p=%0d exp done=1 lat=5 p=143", done, lat, p);
    end
    step();
  endtask

  task automatic test_zero();
    int lat;
    int busy_cnt;
    a = 4'd0; b = 4'd9; start = 1'b1;
    step();
    start = 1'b0;
    lat = 1; busy_cnt = 0;
    while (!done && lat < 20) begin
      if (busy) busy_cnt++;
      step();
      lat++;
    end
    checks++;
    if (done !== 1'b1 || lat !== ZLAT) begin
      failures++;
      $display("FAIL zero_latency got done=%b lat=%0d exp done=1 lat=%0d", done, lat, ZLAT);
    end
    checks++;
    if (busy_cnt !== ZBUSY) begin
      failures++;
      $display("FAIL zero_busy got=%0d exp=%0d", busy_cnt, ZBUSY);
    end
    checks++;
    if (p !== 8'h00) begin
      failures++;
      $display("FAIL zero_p got=%h exp=00", p);
    end
    step();
  endtask

  task automatic test_sweep();
    int lat;
    int exp_lat;
    logic [7:0] exp_p;
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        exp_p = 8'(ai * bi);
        exp_lat = (ai == 0 || bi == 0) ? ZLAT : 5;
        a = 4'(ai); b = 4'(bi); start = 1'b1;
        step();
        start = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin
          step();
          lat++;
        end
        checks++;
        if (done !== 1'b1 || p !== exp_p) begin
          failures++;
          $display("FAIL sweep_p a=%0d b=%0d got p=%0d done=%b exp p=%0d done=1", ai, bi, p, done, exp_p);
        end
        checks++;
        if (lat !== exp_lat) begin
          failures++;
          $display("FAIL sweep_lat a=%0d b=%0d got=%0d exp=%0d", ai, bi, lat, exp_lat);
        end
        step();
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    test_zero();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
